// File: rtl/coin_feeder.sv
// Toy vending machine customer driver: issues PRICE coin pulses per toy, counts returned toys, flags a timeout.
// Optional COIN_GAP_EN inserts one idle cycle between consecutive coins. All outputs are registered.
`timescale 1ns/1ps
module coin_feeder #(
  parameter int PRICE   = 2,
  parameter int QW      = 4,
  parameter int TIMEOUT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [QW-1:0] qty,
  output logic          coin,
  input  logic          toy,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [QW-1:0] toys_got
);

  localparam int CW = (PRICE > 1) ? $clog2(PRICE) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INSERT, S_WAIT_TOY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_coin_cnt, w_coin_cnt_nxt;
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic [QW-1:0] r_qty, w_qty_nxt;
  logic [QW-1:0] r_toys_got, w_toys_got_nxt;
  logic          r_coin, w_coin_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  logic [QW-1:0] w_toys_inc;
  logic          w_last_coin;

  assign w_toys_inc  = r_toys_got + QW'(1);
  assign w_last_coin = (r_coin_cnt == CW'(PRICE - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_coin_cnt_nxt = r_coin_cnt;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_qty_nxt      = r_qty;
    w_toys_got_nxt = r_toys_got;
    w_coin_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_toys_got_nxt = '0;
          w_error_nxt    = 1'b0;
          if (qty != '0) begin
            w_qty_nxt      = qty;
            w_done_nxt     = 1'b0;
            w_state_nxt    = S_INSERT;
            w_coin_nxt     = 1'b1;
            w_coin_cnt_nxt = '0;
            w_busy_nxt     = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_INSERT: begin
`ifdef COIN_GAP_EN
        // r_coin low here means this is the gap cycle; the next cycle carries a coin
        if (!r_coin) begin
          w_coin_nxt = 1'b1;
        end else if (w_last_coin) begin
          w_state_nxt    = S_WAIT_TOY;
          w_tmo_cnt_nxt  = '0;
          w_coin_cnt_nxt = '0;
        end else begin
          w_coin_cnt_nxt = r_coin_cnt + CW'(1);
        end
`else
        if (w_last_coin) begin
          w_state_nxt    = S_WAIT_TOY;
          w_tmo_cnt_nxt  = '0;
          w_coin_cnt_nxt = '0;
        end else begin
          w_coin_cnt_nxt = r_coin_cnt + CW'(1);
          w_coin_nxt     = 1'b1;
        end
`endif
      end
      S_WAIT_TOY: begin
        if (toy) begin
          w_toys_got_nxt = w_toys_inc;
          if (w_toys_inc == r_qty) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt    = S_INSERT;
            w_coin_nxt     = 1'b1;
            w_coin_cnt_nxt = '0;
          end
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_error_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_coin_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_qty      <= '0;
      r_toys_got <= '0;
      r_coin     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_coin_cnt <= w_coin_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_qty      <= w_qty_nxt;
      r_toys_got <= w_toys_got_nxt;
      r_coin     <= w_coin_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign coin     = r_coin;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign toys_got = r_toys_got;

endmodule
